scan_test_ctrl: RTL and testbench

Scan-chain test controller: the tester-side initiator that drives a scan-wrapped block (scan_mode, scan_in, scan_clk, scan_clr) and reads its scan_out. One `start` runs a full sequence: clear the chain, shift a pattern in, do one functional capture, shift the response out. It then compares the response against an expected vector under a mask and reports pass/fail. It sits next to a scan-wrapped top in the same system clock domain and generates the slow scan clock itself.

---
 rtl/scan_test_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_scan_test_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_test_ctrl.sv
// Scan-chain test controller.
// One start runs: chain clear, shift pattern in (MSB first), one functional
// capture pulse, then shift the response out. The response is compared with
// the expected vector under a mask. The slow scan clock is generated here
// from the system clock. Every output comes straight from a flop: the next
// output values are decoded from the next state and then registered.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 7,
  parameter int DIV       = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start_i,
  input  logic [CHAIN_LEN-1:0] pattern_i,
  input  logic [CHAIN_LEN-1:0] expect_i,
  input  logic [CHAIN_LEN-1:0] mask_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CHAIN_LEN-1:0] response_o,
  output logic                 scan_mode_o,
  output logic                 scan_in_o,
  output logic                 scan_clk_o,
  output logic                 scan_clr_o,
  input  logic                 scan_out_i
);

  localparam int PW = $clog2(CHAIN_LEN + 1);
  localparam int HW = $clog2(DIV + 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(CHAIN_LEN - 1);
  localparam logic [HW-1:0] LAST_PH    = HW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SHIFT_IN, S_CAPTURE, S_SHIFT_OUT, S_DONE
  } state_t;

  // Compare result: every masked bit of the response must equal expect.
  function automatic logic masked_match(input logic [CHAIN_LEN-1:0] r,
                                        input logic [CHAIN_LEN-1:0] e,
                                        input logic [CHAIN_LEN-1:0] m);
    return (((r ^ e) & m) == {CHAIN_LEN{1'b0}});
  endfunction

  state_t               state_q, state_d;
  logic [HW-1:0]        phase_q, phase_d, adv_phase;
  logic                 half_q, half_d, adv_half;     // 0 = low phase, 1 = high phase
  logic [PW-1:0]        pulse_q, pulse_d, adv_pulse;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;                 // shifted left once per SHIFT_IN pulse
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] mask_q, mask_d;
  logic [CHAIN_LEN-1:0] resp_sh_q;
  logic [CHAIN_LEN-1:0] response_q;
  logic                 pass_q;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 mode_q, mode_d, sin_q, sin_d, sclk_q, sclk_d, sclr_q, sclr_d;
  logic                 end_of_pulse;
  logic                 sample_en;

  // Phase/half/pulse counter values one step further inside a scan pulse
  always_comb begin
    if (phase_q == LAST_PH) begin
      adv_phase = {HW{1'b0}};
      adv_half  = ~half_q;
      if (half_q) begin
        adv_pulse = pulse_q + PW'(32'd1);
      end else begin
        adv_pulse = pulse_q;
      end
    end else begin
      adv_phase = phase_q + HW'(32'd1);
      adv_half  = half_q;
      adv_pulse = pulse_q;
    end
  end

  assign end_of_pulse = half_q && (phase_q == LAST_PH);
  // scan_out is taken on the edge where scan_clk rises (end of the low phase)
  assign sample_en = (state_q == S_SHIFT_OUT) && !half_q && (phase_q == LAST_PH);

  // Next-state, counter and operand-latch decode
  always_comb begin
    state_d = state_q;
    phase_d = adv_phase;
    half_d  = adv_half;
    pulse_d = adv_pulse;
    pat_d   = pat_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          pat_d   = pattern_i;
          exp_d   = expect_i;
          mask_d  = mask_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (phase_q == LAST_PH) begin
          state_d = S_SHIFT_IN;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_SHIFT_IN: begin
        if (end_of_pulse) begin
          pat_d = pat_q << 1;
          if (pulse_q == LAST_PULSE) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_SHIFT_IN;
          end
        end else begin
          state_d = S_SHIFT_IN;
        end
      end
      S_CAPTURE: begin
        if (end_of_pulse) begin
          state_d = S_SHIFT_OUT;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_SHIFT_OUT: begin
        if (end_of_pulse && (pulse_q == LAST_PULSE)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Counters restart on every state entry so they never wrap inside a state
    if (state_d != state_q) begin
      phase_d = {HW{1'b0}};
      half_d  = 1'b0;
      pulse_d = {PW{1'b0}};
    end else begin
      phase_d = phase_d;
    end
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    mode_d = 1'b0;
    sin_d  = 1'b0;
    sclk_d = 1'b0;
    sclr_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_CLEAR: begin
        busy_d = 1'b1;
        mode_d = 1'b1;
        sclr_d = 1'b1;
      end
      S_SHIFT_IN: begin
        busy_d = 1'b1;
        mode_d = 1'b1;
        sin_d  = pat_d[CHAIN_LEN-1];
        sclk_d = half_d;
      end
      S_CAPTURE: begin
        busy_d = 1'b1;
        sclk_d = half_d;
      end
      S_SHIFT_OUT: begin
        busy_d = 1'b1;
        mode_d = 1'b1;
        sclk_d = half_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counters and latched operands
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      phase_q <= {HW{1'b0}};
      half_q  <= 1'b0;
      pulse_q <= {PW{1'b0}};
      pat_q   <= {CHAIN_LEN{1'b0}};
      exp_q   <= {CHAIN_LEN{1'b0}};
      mask_q  <= {CHAIN_LEN{1'b0}};
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      pulse_q <= pulse_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
    end
  end

  // Response shift register: first sample ends up in the MSB
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      resp_sh_q <= {CHAIN_LEN{1'b0}};
    end else if (sample_en) begin
      resp_sh_q <= (resp_sh_q << 1) | CHAIN_LEN'(scan_out_i);
    end else begin
      resp_sh_q <= resp_sh_q;
    end
  end

  // Registered outputs; result and response update only on DONE entry
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= 1'b0;
      sin_q      <= 1'b0;
      sclk_q     <= 1'b0;
      sclr_q     <= 1'b0;
      pass_q     <= 1'b0;
      response_q <= {CHAIN_LEN{1'b0}};
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      mode_q <= mode_d;
      sin_q  <= sin_d;
      sclk_q <= sclk_d;
      sclr_q <= sclr_d;
      if (state_d == S_DONE) begin
        response_q <= resp_sh_q;
        pass_q     <= masked_match(resp_sh_q, exp_q, mask_q);
      end else begin
        response_q <= response_q;
        pass_q     <= pass_q;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign response_o  = response_q;
  assign scan_mode_o = mode_q;
  assign scan_in_o   = sin_q;
  assign scan_clk_o  = sclk_q;
  assign scan_clr_o  = sclr_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: two instances (7-flop/DIV=2 and 1-flop/DIV=1),
// each driving a behavioural scan chain whose capture inverts every bit.
// Stimulus pushes expected results into scoreboards; monitors pop on done.
module tb_scan_test_ctrl;

  localparam int L0 = 7;
  localparam int D0 = 2;
  localparam int L1 = 1;
  localparam int D1 = 1;

  typedef struct {
    logic [6:0] resp;
    logic       pass;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  // DUT0 signals
  logic          start0;
  logic [L0-1:0] pat0, exp0, msk0, resp0;
  logic          busy0, done0, pass0, smode0, sin0, sclk0, sclr0, sout0;
  logic [L0-1:0] ch0 = '0;
  // DUT1 signals
  logic          start1;
  logic [L1-1:0] pat1, exp1, msk1, resp1;
  logic          busy1, done1, pass1, smode1, sin1, sclk1, sclr1, sout1;
  logic [L1-1:0] ch1 = '0;

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  scan_test_ctrl #(.CHAIN_LEN(L0), .DIV(D0)) u_dut0 (
    .clk(clk), .clr(clr), .start_i(start0), .pattern_i(pat0), .expect_i(exp0),
    .mask_i(msk0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .response_o(resp0), .scan_mode_o(smode0), .scan_in_o(sin0),
    .scan_clk_o(sclk0), .scan_clr_o(sclr0), .scan_out_i(sout0));

  scan_test_ctrl #(.CHAIN_LEN(L1), .DIV(D1)) u_dut1 (
    .clk(clk), .clr(clr), .start_i(start1), .pattern_i(pat1), .expect_i(exp1),
    .mask_i(msk1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .response_o(resp1), .scan_mode_o(smode1), .scan_in_o(sin1),
    .scan_clk_o(sclk1), .scan_clr_o(sclr1), .scan_out_i(sout1));

  // 7-flop chain model: shift in scan mode, invert on capture
  always @(posedge sclk0 or posedge sclr0) begin
    if (sclr0) ch0 <= '0;
    else if (smode0) ch0 <= {ch0[L0-2:0], sin0};
    else ch0 <= ~ch0;
  end
  assign sout0 = ch0[L0-1];

  // 1-flop chain model
  always @(posedge sclk1 or posedge sclr1) begin
    if (sclr1) ch1 <= '0;
    else if (smode1) ch1 <= sin1;
    else ch1 <= ~ch1;
  end
  assign sout1 = ch1[0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // waveform bookkeeping for DUT0, per run
  int rises, clr_cyc, mode0_cyc, per_bad, setup_bad, hold_bad;
  int last_rise, last_chg, clr_fall, first_rise;
  logic p_busy = 1'b0, p_sclk = 1'b0, p_sin = 1'b0, p_mode = 1'b0, p_sclr = 1'b0;

  // DUT0 monitor: waveform tracking and scoreboard compare on done
  always @(negedge clk) begin
    exp_t e;
    if (!clr) begin
      if (busy0 && !p_busy) begin
        rises = 0; clr_cyc = 0; mode0_cyc = 0; per_bad = 0; setup_bad = 0;
        hold_bad = 0; last_rise = -1; last_chg = cyc; clr_fall = -1; first_rise = -1;
      end
      if (sclr0) clr_cyc++;
      if (p_sclr && !sclr0) clr_fall = cyc;
      if (busy0 && !smode0) mode0_cyc++;
      if (sin0 != p_sin || smode0 != p_mode) begin
        if (last_rise >= 0 && cyc - last_rise < D0) hold_bad++;
        last_chg = cyc;
      end
      if (sclk0 && !p_sclk) begin
        rises++;
        if (cyc - last_chg < D0) setup_bad++;
        if (last_rise >= 0 && cyc - last_rise != 2 * D0) per_bad++;
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
      end
      if (done0) begin
        if (sb0.size() == 0) begin
          chk("dut0_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb0.pop_front();
          chk("dut0_done_cycle", cyc, e.cyc);
          chk("dut0_response", {25'd0, resp0}, {25'd0, e.resp});
          chk("dut0_pass", {31'd0, pass0}, {31'd0, e.pass});
          chk("dut0_busy_in_done", {31'd0, busy0}, 32'd0);
          chk("dut0_scan_mode_in_done", {31'd0, smode0}, 32'd0);
          chk("dut0_clk_rises", rises, 2 * L0 + 1);
          chk("dut0_clk_period_errs", per_bad, 0);
          chk("dut0_setup_errs", setup_bad, 0);
          chk("dut0_hold_errs", hold_bad, 0);
          chk("dut0_clr_cycles", clr_cyc, D0);
          chk("dut0_clr_to_rise", first_rise - clr_fall, D0);
          chk("dut0_mode0_cycles", mode0_cyc, 2 * D0);
        end
      end
    end
    p_busy = busy0; p_sclk = sclk0; p_sin = sin0; p_mode = smode0; p_sclr = sclr0;
  end

  // DUT1 monitor: scoreboard compare on done
  always @(negedge clk) begin
    exp_t e;
    if (!clr && done1) begin
      if (sb1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb1.pop_front();
        chk("dut1_done_cycle", cyc, e.cyc);
        chk("dut1_response", {31'd0, resp1}, {31'd0, e.resp[0]});
        chk("dut1_pass", {31'd0, pass1}, {31'd0, e.pass});
        chk("dut1_busy_in_done", {31'd0, busy1}, 32'd0);
      end
    end
  end

  // Issue one DUT0 run (called at a negedge) and push its expected result
  task automatic run0(input logic [6:0] p, input logic [6:0] e, input logic [6:0] m,
                      input logic [6:0] r, input logic ps);
    exp_t x;
    pat0 = p; exp0 = e; msk0 = m; start0 = 1'b1;
    x.resp = r; x.pass = ps; x.cyc = cyc + D0 * (4 * L0 + 3) + 1;
    sb0.push_back(x);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic drain0(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb0.size() == 0) break;
      @(negedge clk);
    end
    chk("dut0_drain_timeout", sb0.size(), 0);
    @(negedge clk);
  endtask

  task automatic drain1(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb1.size() == 0) break;
      @(negedge clk);
    end
    chk("dut1_drain_timeout", sb1.size(), 0);
    @(negedge clk);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    exp_t x;
    int c;
    clr = 1'b1;
    start0 = 1'b0; pat0 = '0; exp0 = '0; msk0 = '0;
    start1 = 1'b0; pat1 = '0; exp1 = '0; msk1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs_dut0", {22'd0, busy0, done0, pass0, resp0, smode0, sin0, sclk0, sclr0}, 32'd0);
    chk("rst_outs_dut1", {25'd0, busy1, done1, pass1, resp1, smode1, sin1, sclk1, sclr1}, 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // golden pass
    run0(7'b1011001, 7'b0100110, 7'h7F, 7'b0100110, 1'b1);
    drain0(200);
    // bit 3 mismatch, full mask
    run0(7'b1011001, 7'b0101110, 7'h7F, 7'b0100110, 1'b0);
    drain0(200);
    // bit 3 mismatch masked off
    run0(7'b1011001, 7'b0101110, 7'h77, 7'b0100110, 1'b1);
    drain0(200);
    // all zeros in -> all ones captured
    run0(7'b0000000, 7'b1111111, 7'h7F, 7'b1111111, 1'b1);
    drain0(200);
    // all ones in -> zeros out, bit 0 differs and is compared
    run0(7'b1111111, 7'b0000001, 7'h01, 7'b0000000, 1'b0);
    drain0(200);

    // start pulsed mid-run and in the DONE cycle: both ignored
    c = cyc;
    run0(7'b1011001, 7'b0100110, 7'h7F, 7'b0100110, 1'b1);
    while (cyc < c + 20) @(negedge clk);
    pat0 = 7'b1111111; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < c + 63) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain0(200);
    repeat (80) @(negedge clk);
    chk("dut0_idle_after_ignored_start", {31'd0, busy0}, 32'd0);

    // start held through a whole run: second run begins right after DONE
    c = cyc;
    pat0 = 7'b1011001; exp0 = 7'b0100110; msk0 = 7'h7F; start0 = 1'b1;
    x.resp = 7'b0100110; x.pass = 1'b1; x.cyc = c + 63; sb0.push_back(x);
    x.cyc = c + 64 + 63; sb0.push_back(x);
    while (cyc < c + 65) @(negedge clk);
    start0 = 1'b0;
    drain0(300);
    repeat (80) @(negedge clk);

    // reset mid SHIFT_IN
    c = cyc;
    run0(7'b1011001, 7'b0100110, 7'h7F, 7'b0100110, 1'b1);
    while (cyc < c + 10) @(negedge clk);
    chk("busy_before_mid_reset", {31'd0, busy0}, 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("mid_reset_outs", {22'd0, busy0, done0, pass0, resp0, smode0, sin0, sclk0, sclr0}, 32'd0);
    sb0.delete();
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    run0(7'b1011001, 7'b0100110, 7'h7F, 7'b0100110, 1'b1);
    drain0(200);

    // DIV=1, CHAIN_LEN=1
    pat1 = 1'b1; exp1 = 1'b0; msk1 = 1'b1; start1 = 1'b1;
    x.resp = 7'd0; x.pass = 1'b1; x.cyc = cyc + 8; sb1.push_back(x);
    @(negedge clk);
    start1 = 1'b0;
    drain1(50);
    repeat (20) @(negedge clk);

    chk("dut0_queue_empty", sb0.size(), 0);
    chk("dut1_queue_empty", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
